dmem_sram_ctrl: RTL and testbench
=================================

// Module: dmem_sram_ctrl
// PURPOSE
//   Data-RAM slave sitting directly downstream of the SoC data-memory port (memory arbiter d_mem_* bus).
//   Owns a word-organised on-chip SRAM of 2**MEM_ADDRESS_BITS words with byte-lane writes, a
//   configurable read pipeline, a zero-fill init sequence after reset and a sticky bus-error flag.
// PARAMETERS
//   DATA_WIDTH        32     data word width; byte lanes = DATA_WIDTH/8
//   ADDRESS_BITS      32     byte-address width of the bus
//   MEM_ADDRESS_BITS  12     log2 of SRAM depth in words
//   BASE_ADDRESS      32'h0  byte base of the RAM window, aligned to window size
//   READ_LATENCY      1      cycles from accepted read to d_mem_valid; legal 1..4
//   INIT_ZERO         1      1: zero-fill the whole SRAM after reset before accepting requests
// PORTS
//   clk                 in   1                 system clock
//   rst                 in   1                 asynchronous active-high reset
//   d_mem_read          in   1                 read request
//   d_mem_write         in   1                 write request
//   d_mem_byte_en       in   DATA_WIDTH/8      write byte-lane enables
//   d_mem_address_in    in   ADDRESS_BITS      request byte address
//   d_mem_data_in       in   DATA_WIDTH        write data
//   d_mem_data_out      out  DATA_WIDTH        read data, qualified by d_mem_valid
//   d_mem_address_out   out  ADDRESS_BITS      byte address of the returned read
//   d_mem_valid         out  1                 one-cycle read-return strobe
//   d_mem_ready         out  1                 controller accepts a request this cycle
//   init_done           out  1                 zero-fill complete (tied 1 after reset if INIT_ZERO=0)
//   bus_error           out  1                 sticky error flag, cleared only by rst
// BEHAVIOUR
//   Reset: d_mem_valid=0, d_mem_data_out=0, d_mem_address_out=0, bus_error=0, read pipe flushed;
//     INIT_ZERO=1 -> d_mem_ready=0, init_done=0; INIT_ZERO=0 -> d_mem_ready=1, init_done=1.
//   FSM: INIT -> IDLE. INIT writes 0 to word ptr each cycle, ptr 0..2**MEM_ADDRESS_BITS-1;
//     on last word init_done and d_mem_ready rise next cycle (INIT lasts exactly 2**MEM_ADDRESS_BITS
//     cycles). rst asserted mid-INIT restarts from ptr 0. INIT_ZERO=0 starts in IDLE.
//   Accept: request accepted on rising clk when d_mem_ready & (d_mem_read | d_mem_write).
//     In IDLE d_mem_ready=1 every cycle (fully pipelined, one request/cycle, no back-pressure).
//   Decode: word index = addr[MEM_ADDRESS_BITS+1:2]; addr[1:0] ignored (lanes selected by byte_en).
//     In-window iff addr[ADDRESS_BITS-1:MEM_ADDRESS_BITS+2] == BASE_ADDRESS same bits.
//   Write: in-window -> lanes with byte_en[i]=1 updated at accept edge; byte_en=0 is a legal no-op.
//     Writes produce no d_mem_valid.
//   Read: SRAM sampled at accept edge; data+address travel a READ_LATENCY-deep shift pipe;
//     d_mem_valid high exactly one cycle, READ_LATENCY cycles after accept; back-to-back reads
//     return back-to-back, in order. Read issued the cycle after a write to same word sees new data.
//   Errors (set bus_error, sticky): out-of-window read -> still returns valid with data 0;
//     out-of-window write -> ignored; read&write both high -> neither performed, no valid, error.
//   Requests presented while d_mem_ready=0 are ignored (not queued); no error.
//   d_mem_data_out/address_out hold last returned values when d_mem_valid=0.
// TESTING
//   Reset, INIT_ZERO=1, MEM_ADDRESS_BITS=4 -> ready low exactly 16 cycles, then read 0x3C returns 0.
//   Write 0x10=0xDEADBEEF be=4'hF, then be=4'b0010 data 0x00005500, read 0x10 -> 0xDEAD55EF, latency per param.
//   READ_LATENCY=3, reads 0x0,0x4,0x8 on consecutive cycles -> three consecutive valids, addresses in order.
//   Read BASE_ADDRESS+(4<<MEM_ADDRESS_BITS) -> valid with data 0, bus_error=1 and stays 1 until rst.
//   d_mem_read=d_mem_write=1 at 0x8 -> no valid, word unchanged, bus_error=1.
//   Assert rst mid-INIT at ptr=7 -> valid=0 immediately, INIT restarts, full depth of cycles before ready.

Source files
------------

// File: rtl/dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_sram_ctrl
//  Brief    : Data-RAM slave for the SoC data-memory port. Word-organised
//             SRAM with byte-lane writes, READ_LATENCY-deep read pipe,
//             zero-fill init sequence after reset and a sticky bus error.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_sram_ctrl #(
  parameter int                       DATA_WIDTH       = 32,
  parameter int                       ADDRESS_BITS     = 32,
  parameter int                       MEM_ADDRESS_BITS = 12,
  parameter logic [ADDRESS_BITS-1:0]  BASE_ADDRESS     = '0,
  parameter int                       READ_LATENCY     = 1,
  parameter int                       INIT_ZERO        = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_mem_read,
  input  logic                      d_mem_write,
  input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  output logic                      d_mem_valid,
  output logic                      d_mem_ready,
  output logic                      init_done,
  output logic                      bus_error
);

  localparam int c_lanes = DATA_WIDTH / 8;
  localparam int c_depth = 1 << MEM_ADDRESS_BITS;

  localparam logic [0:0] c_st_init = 1'b0;
  localparam logic [0:0] c_st_idle = 1'b1;

  logic [0:0]                  r_state;
  logic [MEM_ADDRESS_BITS-1:0] r_init_ptr;
  logic                        r_bus_error;

  logic                        w_ready;
  logic                        w_init;
  logic                        w_accept;
  logic                        w_conflict;
  logic                        w_rd_ok;
  logic                        w_wr_ok;
  logic                        w_in_window;
  logic [MEM_ADDRESS_BITS-1:0] w_word_idx;
  logic [DATA_WIDTH-1:0]       w_rd_word;
  logic                        w_unused_addr;

  // Read pipe: stage READ_LATENCY-1 drives the outputs.
  logic                        r_pipe_valid [READ_LATENCY];
  logic [DATA_WIDTH-1:0]       r_pipe_data  [READ_LATENCY];
  logic [ADDRESS_BITS-1:0]     r_pipe_addr  [READ_LATENCY];

  assign w_init     = (r_state == c_st_init);
  assign w_ready    = (r_state == c_st_idle);
  assign w_accept   = w_ready & (d_mem_read | d_mem_write);
  assign w_conflict = d_mem_read & d_mem_write;
  // A read+write collision performs neither operation.
  assign w_rd_ok    = w_accept & d_mem_read  & ~d_mem_write;
  assign w_wr_ok    = w_accept & d_mem_write & ~d_mem_read;
  assign w_word_idx = d_mem_address_in[MEM_ADDRESS_BITS+1:2];

  // Byte offset within the word is irrelevant: lanes come from byte_en.
  assign w_unused_addr = ^d_mem_address_in[1:0];

  // Window decode on the bits above the word index.
  generate
    if (MEM_ADDRESS_BITS + 2 < ADDRESS_BITS) begin : g_window_cmp
      assign w_in_window = (d_mem_address_in[ADDRESS_BITS-1:MEM_ADDRESS_BITS+2] ==
                            BASE_ADDRESS[ADDRESS_BITS-1:MEM_ADDRESS_BITS+2]);
    end else begin : g_window_all
      assign w_in_window = 1'b1;
    end
  endgenerate

  // Init sequencer: sweep every word once, then go idle for good.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= (INIT_ZERO != 0) ? c_st_init : c_st_idle;
      r_init_ptr <= '0;
    end else if (r_state == c_st_init) begin
      r_init_ptr <= r_init_ptr + 1'b1;
      if (&r_init_ptr) begin
        r_state <= c_st_idle;
      end
    end
  end

  // One 8-bit memory per byte lane so lane writes stay independent.
  generate
    for (genvar i = 0; i < c_lanes; i++) begin : g_lane
      logic [7:0]                  r_mem [c_depth];
      logic                        w_we;
      logic [MEM_ADDRESS_BITS-1:0] w_waddr;
      logic [7:0]                  w_wdata;

      assign w_we    = w_init | (w_wr_ok & w_in_window & d_mem_byte_en[i]);
      assign w_waddr = w_init ? r_init_ptr : w_word_idx;
      assign w_wdata = w_init ? 8'h00 : d_mem_data_in[8*i +: 8];

      // Lane storage write port (zero-fill during init, bus writes after).
      always_ff @(posedge clk) begin
        if (w_we) begin
          r_mem[w_waddr] <= w_wdata;
        end
      end

      assign w_rd_word[8*i +: 8] = r_mem[w_word_idx];
    end
  endgenerate

  // Read pipe: sample SRAM at accept, shift; data/address only move with a
  // valid token so the output stage holds the last returned read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_pipe_valid[k] <= 1'b0;
        r_pipe_data[k]  <= '0;
        r_pipe_addr[k]  <= '0;
      end
    end else begin
      r_pipe_valid[0] <= w_rd_ok;
      if (w_rd_ok) begin
        r_pipe_data[0] <= w_in_window ? w_rd_word : '0;
        r_pipe_addr[0] <= d_mem_address_in;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_pipe_valid[k] <= r_pipe_valid[k-1];
        if (r_pipe_valid[k-1]) begin
          r_pipe_data[k] <= r_pipe_data[k-1];
          r_pipe_addr[k] <= r_pipe_addr[k-1];
        end
      end
    end
  end

  // Sticky error: out-of-window access or read/write collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_error <= 1'b0;
    end else if (w_accept & (w_conflict | ~w_in_window)) begin
      r_bus_error <= 1'b1;
    end
  end

  assign d_mem_valid       = r_pipe_valid[READ_LATENCY-1];
  assign d_mem_data_out    = r_pipe_data[READ_LATENCY-1];
  assign d_mem_address_out = r_pipe_addr[READ_LATENCY-1];
  assign d_mem_ready       = w_ready;
  assign init_done         = w_ready;
  assign bus_error         = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_dmem_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_sram_ctrl
//  Brief    : Directed self-checking bench for dmem_sram_ctrl
//             (MEM_ADDRESS_BITS=4, READ_LATENCY=3, INIT_ZERO=1, base 0).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        rd;
  logic        wr;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic [31:0] aout;
  logic        valid;
  logic        ready;
  logic        init_done;
  logic        bus_error;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt;
  int seen;

  dmem_sram_ctrl #(
    .DATA_WIDTH       (32),
    .ADDRESS_BITS     (32),
    .MEM_ADDRESS_BITS (4),
    .BASE_ADDRESS     (32'h0),
    .READ_LATENCY     (3),
    .INIT_ZERO        (1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .d_mem_read        (rd),
    .d_mem_write       (wr),
    .d_mem_byte_en     (be),
    .d_mem_address_in  (addr),
    .d_mem_data_in     (din),
    .d_mem_data_out    (dout),
    .d_mem_address_out (aout),
    .d_mem_valid       (valid),
    .d_mem_ready       (ready),
    .init_done         (init_done),
    .bus_error         (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for one cycle; returns at the negedge after the accept edge.
  task automatic req(input logic r, input logic w, input logic [3:0] b,
                     input logic [31:0] a, input logic [31:0] d);
    rd = r; wr = w; be = b; addr = a; din = d;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; be = 4'h0;
  endtask

  task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int lat;
    req(1'b1, 1'b0, 4'h0, a, 32'h0);
    lat = 1;
    while (!valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 32'd3);
    check({tag, " data"}, dout, exp);
    check({tag, " addr"}, aout, a);
    @(negedge clk);
    check({tag, " valid one cycle"}, {31'b0, valid}, 32'd0);
  endtask

  initial begin
    rd = 1'b0; wr = 1'b0; be = 4'h0; addr = 32'h0; din = 32'h0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst valid",     {31'b0, valid},     32'd0);
    check("rst ready",     {31'b0, ready},     32'd0);
    check("rst init_done", {31'b0, init_done}, 32'd0);
    check("rst bus_error", {31'b0, bus_error}, 32'd0);
    check("rst data_out",  dout, 32'h0);
    check("rst addr_out",  aout, 32'h0);

    // Zero-fill takes exactly 16 cycles
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("init ready-low cycles", cnt, 32'd16);
    check("init_done high", {31'b0, init_done}, 32'd1);
    read_check(32'h3C, 32'h0, "init zero 0x3C");

    // Byte-lane writes, read-after-write next cycle
    req(1'b0, 1'b1, 4'hF,    32'h10, 32'hDEADBEEF);
    req(1'b0, 1'b1, 4'b0010, 32'h10, 32'h00005500);
    read_check(32'h10, 32'hDEAD55EF, "lane write 0x10");
    req(1'b0, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF);
    read_check(32'h12, 32'hDEAD55EF, "be0 noop, unaligned 0x12");
    check("no error yet", {31'b0, bus_error}, 32'd0);

    // Back-to-back reads return back-to-back, in order
    req(1'b0, 1'b1, 4'hF, 32'h0, 32'h11111111);
    req(1'b0, 1'b1, 4'hF, 32'h4, 32'h22222222);
    req(1'b0, 1'b1, 4'hF, 32'h8, 32'h33333333);
    rd = 1'b1; addr = 32'h0;
    @(negedge clk); addr = 32'h4;
    @(negedge clk); addr = 32'h8;
    @(negedge clk); rd = 1'b0;
    check("burst0 valid", {31'b0, valid}, 32'd1);
    check("burst0 addr",  aout, 32'h0);
    check("burst0 data",  dout, 32'h11111111);
    @(negedge clk);
    check("burst1 valid", {31'b0, valid}, 32'd1);
    check("burst1 addr",  aout, 32'h4);
    check("burst1 data",  dout, 32'h22222222);
    @(negedge clk);
    check("burst2 valid", {31'b0, valid}, 32'd1);
    check("burst2 addr",  aout, 32'h8);
    check("burst2 data",  dout, 32'h33333333);
    @(negedge clk);
    check("burst end valid", {31'b0, valid}, 32'd0);
    check("hold data_out",   dout, 32'h33333333);
    check("hold addr_out",   aout, 32'h8);

    // Read and write together: nothing done, error flagged
    req(1'b1, 1'b1, 4'hF, 32'h8, 32'hFFFFFFFF);
    seen = 0;
    repeat (5) begin
      if (valid) seen = 1;
      @(negedge clk);
    end
    check("conflict no valid", seen, 32'd0);
    check("conflict bus_error", {31'b0, bus_error}, 32'd1);
    read_check(32'h8, 32'h33333333, "conflict word unchanged");

    // Async reset while a read return is on the bus
    req(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("pre-reset valid", {31'b0, valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("async rst valid",     {31'b0, valid},     32'd0);
    check("async rst bus_error", {31'b0, bus_error}, 32'd0);
    check("async rst ready",     {31'b0, ready},     32'd0);
    check("async rst data_out",  dout, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reset at ptr=7 restarts the sweep
    repeat (7) @(negedge clk);
    check("mid-init ready", {31'b0, ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("mid-init rst valid", {31'b0, valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (!ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("reinit ready-low cycles", cnt, 32'd16);
    read_check(32'h10, 32'h0, "reinit zero 0x10");
    check("reinit bus_error", {31'b0, bus_error}, 32'd0);

    // Out-of-window read returns zero and sets sticky error
    read_check(32'h40, 32'h0, "oow read 0x40");
    check("oow bus_error", {31'b0, bus_error}, 32'd1);
    req(1'b0, 1'b1, 4'hF, 32'h50, 32'hAAAAAAAA);
    read_check(32'h10, 32'h0, "oow write ignored");
    check("bus_error sticky", {31'b0, bus_error}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
